// File: rtl/crc_mc_engine.sv
// crc_mc_engine
// Multi-channel CRC engine. Each channel keeps its own polynomial, control word
// and committed checksum. One shared shift engine processes a 32-bit data word
// BITS_PER_CYCLE bits per clock. Registers are reached over the Sel/RW bus.
module crc_mc_engine #(
    parameter int          NUM_CH         = 4,
    parameter int          BITS_PER_CYCLE = 8,
    parameter logic [31:0] BASE_ADDR      = 32'h4003_2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Sel,
    input  logic        RW,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        rd_valid,
    output logic        busy,
    output logic        done
);

    localparam int          CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int          N_CYC     = 32 / BITS_PER_CYCLE;
    localparam logic [5:0]  LAST_CNT  = 6'(N_CYC - 1);
    localparam logic [31:0] WIN_BYTES = 32'(16 * NUM_CH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Reorders a word according to a two-bit transpose code.
    // 00 passes the word through, 01 reverses the bits inside each byte,
    // 10 reverses the whole word, and 11 swaps the bytes.
    function automatic logic [31:0] transpose(input logic [31:0] x, input logic [1:0] code);
        logic [31:0] y;
        y = x;
        case (code)
            2'b01: for (int i = 0; i < 32; i++) y[i] = x[(i / 8) * 8 + 7 - (i % 8)];
            2'b10: for (int i = 0; i < 32; i++) y[i] = x[31 - i];
            2'b11: y = {x[7:0], x[15:8], x[23:16], x[31:24]};
            default: y = x;
        endcase
        return y;
    endfunction

    // Per-channel context.
    logic [31:0]       checksum [NUM_CH];
    logic [31:0]       gpoly    [NUM_CH];
    logic [31:0]       ctrl     [NUM_CH];
    logic [NUM_CH-1:0] err;

    // Shared engine state.
    state_t            state_q, state_d;
    logic [CH_W-1:0]   active_ch;
    logic [5:0]        cnt;
    logic [31:0]       crc_q, crc_n;
    logic [31:0]       sreg_q, sreg_n;

    // Bus decode.
    logic [31:0]       offset;
    logic              in_range;
    logic [CH_W-1:0]   ch;
    logic [1:0]        reg_sel;
    logic [31:0]       sel_ctrl;
    logic [31:0]       wr_t;
    logic              wr_hit, rd_req;
    logic              wr_data_hit, start, data_err, cfg_err;
    logic [31:0]       rd_next;

    // The active channel's polynomial and width drive the shift datapath.
    logic [31:0]       act_ctrl;
    logic              wide;
    logic [31:0]       poly;

    assign offset      = addr - BASE_ADDR;
    assign in_range    = (addr >= BASE_ADDR) && (offset < WIN_BYTES);
    assign ch          = offset[CH_W+3:4];
    assign reg_sel     = offset[3:2];
    assign sel_ctrl    = ctrl[ch];
    assign wr_t        = transpose(data_wr, sel_ctrl[31:30]);
    assign wr_hit      = Sel && RW && in_range;
    assign rd_req      = Sel && !RW;
    assign wr_data_hit = wr_hit && (reg_sel == 2'd0) && !sel_ctrl[25];
    assign busy        = (state_q == SHIFT);
    assign done        = busy && (cnt == LAST_CNT);
    assign start       = wr_data_hit && (state_q == IDLE);
    assign data_err    = wr_data_hit && busy;
    assign cfg_err     = wr_hit && busy && (ch == active_ch)
                         && ((reg_sel == 2'd1) || (reg_sel == 2'd2));

    assign act_ctrl    = ctrl[active_ch];
    assign wide        = act_ctrl[24];
    assign poly        = wide ? gpoly[active_ch] : {16'h0000, gpoly[active_ch][15:0]};

    // Next-state logic: start on an accepted data word, return after the last shift cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt == LAST_CNT) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Advance the CRC by BITS_PER_CYCLE message bits, MSB of the shift register first.
    always_comb begin
        logic fb;
        fb     = 1'b0;
        crc_n  = crc_q;
        sreg_n = sreg_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            fb     = (wide ? crc_n[31] : crc_n[15]) ^ sreg_n[31];
            crc_n  = (crc_n << 1) ^ (fb ? poly : 32'h0000_0000);
            if (!wide) crc_n[31:16] = 16'h0000;
            sreg_n = sreg_n << 1;
        end
    end

    // Read mux: DATA applies the final XOR and then the read-side transpose.
    always_comb begin
        logic [31:0] xmask;
        xmask   = 32'h0000_0000;
        rd_next = 32'h0000_0000;
        if (in_range) begin
            case (reg_sel)
                2'd0: begin
                    if (sel_ctrl[26]) xmask = sel_ctrl[24] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
                    rd_next = transpose(checksum[ch] ^ xmask, sel_ctrl[29:28]);
                end
                2'd1: rd_next = gpoly[ch];
                2'd2: rd_next = sel_ctrl;
                default: rd_next = {24'h0, 4'(active_ch), 2'b00, err[ch],
                                    busy && (active_ch == ch)};
            endcase
        end
    end

    // FSM state register and shift datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            active_ch <= '0;
            cnt       <= 6'd0;
            crc_q     <= 32'h0000_0000;
            sreg_q    <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            if (start) begin
                active_ch <= ch;
                cnt       <= 6'd0;
                crc_q     <= checksum[ch];
                sreg_q    <= wr_t;
            end else if (busy) begin
                cnt    <= cnt + 6'd1;
                crc_q  <= crc_n;
                sreg_q <= sreg_n;
            end
        end
    end

    // Channel context: configuration writes, direct checksum loads, commits and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                checksum[c] <= 32'hFFFF_FFFF;
                gpoly[c]    <= 32'h0000_1021;
                ctrl[c]     <= 32'h0000_0000;
            end
            err <= '0;
        end else begin
            if (done) checksum[active_ch] <= crc_n;
            if (wr_hit) begin
                case (reg_sel)
                    2'd0: if (sel_ctrl[25])
                              checksum[ch] <= sel_ctrl[24] ? wr_t : {16'h0000, wr_t[15:0]};
                    2'd1: if (!cfg_err) gpoly[ch] <= data_wr;
                    2'd2: if (!cfg_err) ctrl[ch] <= data_wr;
                    default: if (data_wr[1]) err[ch] <= 1'b0;
                endcase
            end
            if (data_err || cfg_err) err[ch] <= 1'b1;
        end
    end

    // Registered read port: data holds until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_rd  <= 32'h0000_0000;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) data_rd <= rd_next;
        end
    end

endmodule
